// File: rtl/rle_dequant_pkg.sv
// Shared constants and state encoding for the run-length expander / dequantiser.
// Also used by its coefficient arithmetic sub-block.
package rle_dequant_pkg;

  localparam int COEF_W  = 32;
  localparam int NCOEF   = 64;
  localparam int IDX_W   = 6;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

endpackage

// File: rtl/rle_dequant_coef_dequant.sv
// Combinational dequantiser: signed level times unsigned quantiser entry.
// The product is saturated to 16 bits and packed as a Q(15,16) coefficient.
module coef_dequant
  import rle_dequant_pkg::*;
#(
  parameter int LEVEL_W = 12,
  parameter int Q_W     = 8,
  parameter int FRAC    = 16
) (
  input  logic signed [LEVEL_W-1:0] level,
  input  logic        [Q_W-1:0]     q,
  output logic        [COEF_W-1:0]  coef
);

  localparam int PROD_W = LEVEL_W + Q_W + 1;
  localparam logic signed [PROD_W-1:0] P_MAX = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] P_MIN = PROD_W'(SAT_MIN);

  logic signed [PROD_W-1:0] level_x;
  logic signed [PROD_W-1:0] q_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [15:0]       clamped;

  always_comb begin
    level_x = PROD_W'(level);
    q_x     = PROD_W'({1'b0, q});
    prod    = level_x * q_x;
    if (prod > P_MAX)      clamped = 16'sh7FFF;
    else if (prod < P_MIN) clamped = 16'sh8000;
    else                   clamped = prod[15:0];
    coef = {clamped, {FRAC{1'b0}}};
  end

endmodule

// File: rtl/rle_dequant.sv
// Expands (run, level, eob) symbols into a dequantised 64-coefficient block
// in zigzag order and offers the finished block over a valid/ready handshake.
module rle_dequant
  import rle_dequant_pkg::*;
#(
  parameter int LEVEL_W = 12,
  parameter int Q_W     = 8,
  parameter int FRAC    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sym_valid,
  output logic                      sym_ready,
  input  logic [5:0]                sym_run,
  input  logic [LEVEL_W-1:0]        sym_level,
  input  logic                      sym_eob,
  input  logic [NCOEF*Q_W-1:0]      qtable,
  output logic [COEF_W*NCOEF-1:0]   zigzag,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      err_ovr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [5:0]         run_cnt_q, run_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               err_q, err_d;
  logic               live_q, live_d;
  logic               wr_en;
  logic               clear;
  logic               accept;
  logic [LEVEL_W-1:0] dq_level;
  logic [Q_W-1:0]     dq_q;
  logic [COEF_W-1:0]  dq_coef;
  logic [COEF_W-1:0]  coef_q [NCOEF];
  logic [COEF_W-1:0]  coef_d [NCOEF];

  // live_q keeps sym_ready low until the first clock after reset release.
  assign sym_ready = live_q && (state_q == ST_FILL);
  assign blk_valid = (state_q == ST_OUT);
  assign err_ovr   = err_q;
  assign accept    = sym_valid && sym_ready;
  assign dq_level  = (state_q == ST_EXPAND) ? level_q : sym_level;
  assign dq_q      = qtable[idx_q*Q_W +: Q_W];

  coef_dequant #(
    .LEVEL_W (LEVEL_W),
    .Q_W     (Q_W),
    .FRAC    (FRAC)
  ) u_coef_dequant (
    .level (dq_level),
    .q     (dq_q),
    .coef  (dq_coef)
  );

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    run_cnt_d = run_cnt_q;
    level_d   = level_q;
    err_d     = err_q;
    live_d    = 1'b1;
    wr_en     = 1'b0;
    clear     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (sym_eob) begin
            state_d = ST_OUT;
          end else if (sym_run == 6'd0) begin
            wr_en = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = ST_OUT;
          end else begin
            run_cnt_d = sym_run;
            level_d   = sym_level;
            state_d   = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (run_cnt_q != 6'd0) begin
          // Zeros are already in the file; a skip only advances the index.
          run_cnt_d = run_cnt_q - 6'd1;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            err_d   = 1'b1;
            state_d = ST_OUT;
          end
        end else begin
          wr_en   = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_q == LAST_IDX) ? ST_OUT : ST_FILL;
        end
      end
      ST_OUT: begin
        if (blk_ready) begin
          clear     = 1'b1;
          idx_d     = '0;
          run_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NCOEF; k++) begin
      coef_d[k] = clear ? '0 : coef_q[k];
    end
    if (wr_en) coef_d[idx_q] = dq_coef;
  end

  // NOTE: the coefficient file is reset because zigzag must read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      idx_q     <= '0;
      run_cnt_q <= '0;
      level_q   <= '0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      level_q   <= level_d;
      err_q     <= err_d;
      live_q    <= live_d;
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= coef_d[k];
    end
  end

  for (genvar k = 0; k < NCOEF; k++) begin : g_zz
    assign zigzag[COEF_W*k +: COEF_W] = coef_q[k];
  end

endmodule

// File: tb/tb_rle_dequant.sv
// Self-checking bench for rle_dequant: expected blocks are queued as symbols
// are driven and compared when the block is offered.
module tb_rle_dequant;

  logic          clk = 1'b0;
  logic          rst;
  logic          sym_valid;
  logic          sym_ready;
  logic [5:0]    sym_run;
  logic [11:0]   sym_level;
  logic          sym_eob;
  logic [511:0]  qtable;
  logic [2047:0] zigzag;
  logic          blk_valid;
  logic          blk_ready;
  logic          err_ovr;

  typedef struct packed {
    logic          err;
    logic [2047:0] zz;
  } blk_t;

  typedef struct {
    logic signed [11:0] lvl;
    logic [7:0]         q;
    logic [31:0]        exp;
  } dq_vec_t;

  blk_t    sb[$];
  dq_vec_t vecs[8];
  int      n_vec = 0;
  int      n_err = 0;

  rle_dequant dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_run   (sym_run),
    .sym_level (sym_level),
    .sym_eob   (sym_eob),
    .qtable    (qtable),
    .zigzag    (zigzag),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .err_ovr   (err_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_q_all(input logic [7:0] v);
    for (int k = 0; k < 64; k++) qtable[8*k +: 8] = v;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_sym(input logic [5:0] run, input logic [11:0] lvl, input logic eob);
    bit done = 1'b0;
    sym_run   = run;
    sym_level = lvl;
    sym_eob   = eob;
    sym_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sym_ready) done = 1'b1;
      @(posedge clk);
    end
    #1;
    sym_valid = 1'b0;
    if (!done) check("sym_ready wait", 32'(sym_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int i = 0;
    while (!blk_valid && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (!blk_valid) check("blk_valid wait", 32'(blk_valid), 32'd1);
  endtask

  task automatic compare_block(input string tag);
    blk_t e;
    int   bad;
    if (sb.size() == 0) begin
      check({tag, " unexpected block"}, 32'(blk_valid), 32'd0);
      return;
    end
    e   = sb.pop_front();
    bad = 0;
    for (int k = 63; k >= 0; k--) begin
      if (zigzag[32*k +: 32] !== e.zz[32*k +: 32]) bad = k;
    end
    check($sformatf("%s coef%0d", tag, bad), zigzag[32*bad +: 32], e.zz[32*bad +: 32]);
    check({tag, " err_ovr"}, 32'(err_ovr), 32'(e.err));
  endtask

  task automatic handshake(input string tag);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check({tag, " blk_valid drop"}, 32'(blk_valid), 32'd0);
    check({tag, " zigzag cleared"}, 32'(|zigzag), 32'd0);
    check({tag, " err cleared"}, 32'(err_ovr), 32'd0);
    check({tag, " sym_ready back"}, 32'(sym_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t e;

    vecs[0] = '{12'sd2047,  8'd255, 32'h7FFF0000};
    vecs[1] = '{-12'sd2048, 8'd255, 32'h80000000};
    vecs[2] = '{12'sd100,   8'd0,   32'h00000000};
    vecs[3] = '{-12'sd1,    8'd255, 32'hFF010000};
    vecs[4] = '{12'sd128,   8'd255, 32'h7F800000};
    vecs[5] = '{12'sd129,   8'd255, 32'h7FFF0000};
    vecs[6] = '{-12'sd128,  8'd255, 32'h80800000};
    vecs[7] = '{-12'sd129,  8'd255, 32'h80000000};

    rst       = 1'b0;
    sym_valid = 1'b0;
    sym_run   = '0;
    sym_level = '0;
    sym_eob   = 1'b0;
    blk_ready = 1'b0;
    qtable    = '0;
    set_q_all(8'd1);

    // Reset state, then reset in the middle of a zero run.
    #1;
    check("rst sym_ready", 32'(sym_ready), 32'd0);
    check("rst blk_valid", 32'(blk_valid), 32'd0);
    check("rst zigzag", 32'(|zigzag), 32'd0);
    #21;
    rst = 1'b1;
    check("release sym_ready before clk", 32'(sym_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release sym_ready after clk", 32'(sym_ready), 32'd1);
    send_sym(6'd0, 12'd3, 1'b0);
    check("pre-reset coef0", zigzag[31:0], 32'h00030000);
    send_sym(6'd20, 12'd5, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midexp zigzag", 32'(|zigzag), 32'd0);
    check("midexp blk_valid", 32'(blk_valid), 32'd0);
    check("midexp err_ovr", 32'(err_ovr), 32'd0);
    check("midexp sym_ready", 32'(sym_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midexp sym_ready after", 32'(sym_ready), 32'd1);

    // Full block of 64 literal symbols.
    e = '0;
    for (int k = 0; k < 64; k++) e.zz[32*k +: 32] = 32'(k + 1) << 16;
    sb.push_back(e);
    for (int k = 0; k < 64; k++) begin
      send_sym(6'd0, 12'(k + 1), 1'b0);
      if (k == 62) check("full blk_valid early", 32'(blk_valid), 32'd0);
    end
    check("full blk_valid latency", 32'(blk_valid), 32'd1);
    wait_valid();
    compare_block("full");
    handshake("full");

    // Literal, run, then EOB with non-unit quantisers.
    qtable[7:0]   = 8'd16;
    qtable[39:32] = 8'd10;
    e = '0;
    e.zz[31:0]    = 32'hFFB00000;
    e.zz[159:128] = 32'h00140000;
    sb.push_back(e);
    send_sym(6'd0, -12'sd5, 1'b0);
    send_sym(6'd3, 12'sd2, 1'b0);
    send_sym(6'd0, 12'd0, 1'b1);
    check("eob blk_valid latency", 32'(blk_valid), 32'd1);
    wait_valid();
    compare_block("runeob");
    handshake("runeob");

    // Dequantiser table: one literal at index 0 per block.
    for (int v = 0; v < 8; v++) begin
      set_q_all(8'd1);
      qtable[7:0] = vecs[v].q;
      e = '0;
      e.zz[31:0] = vecs[v].exp;
      sb.push_back(e);
      send_sym(6'd0, vecs[v].lvl, 1'b0);
      send_sym(6'd0, 12'd0, 1'b1);
      wait_valid();
      compare_block($sformatf("dq%0d", v));
      handshake($sformatf("dq%0d", v));
    end

    // Overrun: run pushes the level past index 63.
    set_q_all(8'd1);
    e = '0;
    e.err = 1'b1;
    for (int k = 0; k < 60; k++) e.zz[32*k +: 32] = 32'h00010000;
    sb.push_back(e);
    for (int k = 0; k < 60; k++) send_sym(6'd0, 12'd1, 1'b0);
    send_sym(6'd10, 12'd1, 1'b0);
    wait_valid();
    compare_block("ovr");
    check("ovr coef63", zigzag[2047:2016], 32'h0);
    handshake("ovr");

    // Run of 63 from index 0 lands exactly on the last coefficient.
    e = '0;
    e.zz[2047:2016] = 32'h00070000;
    sb.push_back(e);
    send_sym(6'd63, 12'd7, 1'b0);
    wait_valid();
    compare_block("run63");
    handshake("run63");

    // Backpressure with a symbol held by the producer.
    e = '0;
    e.zz[31:0] = 32'h00090000;
    sb.push_back(e);
    send_sym(6'd0, 12'd9, 1'b0);
    send_sym(6'd0, 12'd0, 1'b1);
    wait_valid();
    sym_run   = 6'd0;
    sym_level = 12'd4;
    sym_eob   = 1'b0;
    sym_valid = 1'b1;
    e = '0;
    e.zz[31:0] = 32'h00040000;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i % 4 == 0) begin
        check($sformatf("bp%0d coef0", i), zigzag[31:0], 32'h00090000);
        check($sformatf("bp%0d sym_ready", i), 32'(sym_ready), 32'd0);
      end
    end
    check("bp blk_valid held", 32'(blk_valid), 32'd1);
    compare_block("bpA");
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check("bp blk_valid drop", 32'(blk_valid), 32'd0);
    @(negedge clk);
    check("bp held symbol ready", 32'(sym_ready), 32'd1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    check("bp held symbol written", zigzag[31:0], 32'h00040000);
    send_sym(6'd0, 12'd0, 1'b1);
    wait_valid();
    compare_block("bpB");
    handshake("bpB");

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
